// File: rtl/ref_pix_ar_arbiter.sv
// Round-robin arbiter sharing the reference-pixel AXI AR channel between two miss FIFOs.
// Optional perf counters: define REF_PIX_AR_ARB_PERF_CNT_EN.
module ref_pix_ar_arbiter #(
    parameter int          AXI_ADDR_WDTH   = 32,
    parameter int          AXI_ID_WDTH     = 4,
    parameter logic [7:0]  AR_LEN          = 8'd7,
    parameter logic [2:0]  AR_SIZE         = 3'd4,
    parameter int          MAX_OUTSTANDING = 8,
    parameter int          CNT_WDTH        = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req0_ar_valid,
    input  logic [AXI_ADDR_WDTH-1:0] req0_ar_addr,
    output logic                     req0_ar_pop,
    input  logic                     req1_ar_valid,
    input  logic [AXI_ADDR_WDTH-1:0] req1_ar_addr,
    output logic                     req1_ar_pop,
    output logic                     ref_pix_axi_arvalid,
    input  logic                     ref_pix_axi_arready,
    output logic [AXI_ADDR_WDTH-1:0] ref_pix_axi_araddr,
    output logic [AXI_ID_WDTH-1:0]   ref_pix_axi_arid,
    output logic [7:0]               ref_pix_axi_arlen,
    output logic [2:0]               ref_pix_axi_arsize,
    output logic [1:0]               ref_pix_axi_arburst,
    input  logic                     ref_pix_axi_rvalid,
    input  logic                     ref_pix_axi_rready,
    input  logic                     ref_pix_axi_rlast,
`ifdef REF_PIX_AR_ARB_PERF_CNT_EN
    output logic [31:0]              perf_grant0_cnt,
    output logic [31:0]              perf_grant1_cnt,
    output logic [31:0]              perf_stall_cnt,
`endif
    output logic [CNT_WDTH-1:0]      outstanding_cnt,
    output logic                     arb_err
);

    localparam logic [CNT_WDTH-1:0] MAX_CNT = CNT_WDTH'(MAX_OUTSTANDING);

    logic slot_free;
    logic credit_ok;
    logic any_req;
    logic load;
    logic winner;
    logic dec;
    logic last_grant;

    assign slot_free = !ref_pix_axi_arvalid | ref_pix_axi_arready;
    assign credit_ok = outstanding_cnt < MAX_CNT;
    assign any_req   = req0_ar_valid | req1_ar_valid;
    assign load      = !reset & slot_free & credit_ok & any_req;
    assign dec       = ref_pix_axi_rvalid & ref_pix_axi_rready & ref_pix_axi_rlast;

    assign ref_pix_axi_arlen   = AR_LEN;
    assign ref_pix_axi_arsize  = AR_SIZE;
    assign ref_pix_axi_arburst = 2'b01;

    // Pick the winner: a lone requester wins, contention goes to the one not served last.
    always_comb begin
        winner = req1_ar_valid;
        if (req0_ar_valid & req1_ar_valid) begin
            winner = ~last_grant;
        end
    end

    assign req0_ar_pop = load & !winner;
    assign req1_ar_pop = load & winner;

    // AR register: load the winner when the slot frees, else retire an accepted AR.
    always_ff @(posedge clk) begin
        if (reset) begin
            ref_pix_axi_arvalid <= 1'b0;
            ref_pix_axi_araddr  <= '0;
            ref_pix_axi_arid    <= '0;
        end else if (load) begin
            ref_pix_axi_arvalid <= 1'b1;
            ref_pix_axi_araddr  <= winner ? req1_ar_addr : req0_ar_addr;
            ref_pix_axi_arid    <= AXI_ID_WDTH'(winner);
        end else if (ref_pix_axi_arready) begin
            ref_pix_axi_arvalid <= 1'b0;
        end
    end

    // Round-robin pointer, moved only by an actual load.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (load) begin
            last_grant <= winner;
        end
    end

    // Outstanding-burst credits: +1 per load, -1 per RLAST; underflow is flagged.
    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding_cnt <= '0;
            arb_err         <= 1'b0;
        end else begin
            if (dec && outstanding_cnt == '0) begin
                arb_err <= 1'b1;
            end
            case ({load, dec})
                2'b10: outstanding_cnt <= outstanding_cnt + CNT_WDTH'(1);
                2'b01: begin
                    if (outstanding_cnt != '0) begin
                        outstanding_cnt <= outstanding_cnt - CNT_WDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef REF_PIX_AR_ARB_PERF_CNT_EN
    logic stall;
    assign stall = !reset & any_req & slot_free & !credit_ok;

    // Grant and credit-stall statistics, free-running and wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_grant0_cnt <= '0;
            perf_grant1_cnt <= '0;
            perf_stall_cnt  <= '0;
        end else begin
            if (req0_ar_pop) perf_grant0_cnt <= perf_grant0_cnt + 32'd1;
            if (req1_ar_pop) perf_grant1_cnt <= perf_grant1_cnt + 32'd1;
            if (stall)       perf_stall_cnt  <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ref_pix_ar_arbiter.sv
// Scoreboard bench for ref_pix_ar_arbiter: FIFO models, a rule-level arbiter
// model feeding an expected-AR queue, and a negedge monitor that checks it.
module tb_ref_pix_ar_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_ar_valid = 1'b0;
    logic [31:0] req0_ar_addr = '0;
    logic        req0_ar_pop;
    logic        req1_ar_valid = 1'b0;
    logic [31:0] req1_ar_addr = '0;
    logic        req1_ar_pop;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid = 1'b0;
    logic        rready = 1'b0;
    logic        rlast = 1'b0;
    logic [3:0]  ocnt;
    logic        err;
`ifdef REF_PIX_AR_ARB_PERF_CNT_EN
    logic [31:0] pg0, pg1, pst;
`endif

    always #5 clk = ~clk;

    ref_pix_ar_arbiter dut (
        .clk                 (clk),
        .reset               (reset),
        .req0_ar_valid       (req0_ar_valid),
        .req0_ar_addr        (req0_ar_addr),
        .req0_ar_pop         (req0_ar_pop),
        .req1_ar_valid       (req1_ar_valid),
        .req1_ar_addr        (req1_ar_addr),
        .req1_ar_pop         (req1_ar_pop),
        .ref_pix_axi_arvalid (arvalid),
        .ref_pix_axi_arready (arready),
        .ref_pix_axi_araddr  (araddr),
        .ref_pix_axi_arid    (arid),
        .ref_pix_axi_arlen   (arlen),
        .ref_pix_axi_arsize  (arsize),
        .ref_pix_axi_arburst (arburst),
        .ref_pix_axi_rvalid  (rvalid),
        .ref_pix_axi_rready  (rready),
        .ref_pix_axi_rlast   (rlast),
`ifdef REF_PIX_AR_ARB_PERF_CNT_EN
        .perf_grant0_cnt     (pg0),
        .perf_grant1_cnt     (pg1),
        .perf_stall_cnt      (pst),
`endif
        .outstanding_cnt     (ocnt),
        .arb_err             (err)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // requester FIFOs, expected ARs and observed ARIDs
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [32:0] exp_q[$];
    bit          hs_ids[$];

    // model state
    bit          m_arv = 0;
    logic [31:0] m_addr = '0;
    bit          m_id = 0;
    int          m_cnt = 0;
    bit          m_err = 0;
    bit          m_last = 1;

    // decision for the current cycle
    bit          d_rst = 1;
    bit          d_load = 0;
    bit          d_win = 0;
    bit          d_dec = 0;
    logic [31:0] d_addr = '0;
    bit          e_pop0 = 0;
    bit          e_pop1 = 0;

    // knobs: k_ardy 0 low / 1 high / 2 random; k_r 0 none / 1 random / 2 drain / 3 force
    bit k_rst = 1;
    int k_ardy = 0;
    int k_r = 0;
    bit mon_on = 0;

    task automatic cycle();
        bit v0, v1, rv, slot;
        @(posedge clk);
        #1;
        if (d_rst) begin
            m_arv = 0; m_addr = '0; m_id = 0;
            m_cnt = 0; m_err = 0; m_last = 1;
            exp_q.delete();
        end else begin
            if (d_load) begin
                m_arv = 1; m_addr = d_addr; m_id = d_win; m_last = d_win;
                exp_q.push_back({d_win, d_addr});
                if (d_win) void'(q1.pop_front());
                else void'(q0.pop_front());
            end else if (m_arv && arready) begin
                m_arv = 0;
            end
            if (d_dec && m_cnt == 0) m_err = 1;
            if (d_load && !d_dec) m_cnt++;
            else if (!d_load && d_dec && m_cnt > 0) m_cnt--;
        end
        reset = k_rst;
        if (k_rst) arready = 1'b0;
        else if (k_ardy == 2) arready = 1'($urandom_range(0, 1));
        else arready = (k_ardy == 1);
        v0 = q0.size() > 0;
        v1 = q1.size() > 0;
        req0_ar_valid = v0;
        req1_ar_valid = v1;
        req0_ar_addr = v0 ? q0[0] : 32'h0;
        req1_ar_addr = v1 ? q1[0] : 32'h0;
        if (k_r == 1) begin
            rvalid = 1'($urandom_range(0, 1));
            rready = 1'($urandom_range(0, 1));
            rlast = (m_cnt > 0) && ($urandom_range(0, 1) == 1);
        end else begin
            rv = (k_r == 3) || (k_r == 2 && m_cnt > 0);
            rvalid = rv; rready = rv; rlast = rv;
        end
        d_rst = k_rst;
        slot = !m_arv || arready;
        d_load = !k_rst && slot && (m_cnt < 8) && (v0 || v1);
        d_win = (v0 && v1) ? !m_last : v1;
        d_addr = d_win ? req1_ar_addr : req0_ar_addr;
        d_dec = rvalid && rready && rlast;
        e_pop0 = d_load && !d_win;
        e_pop1 = d_load && d_win;
    endtask

    // Monitor: pops, state and scoreboard on every AR handshake.
    always @(negedge clk) begin
        if (mon_on) begin
            logic [32:0] e;
            chk("pop0", req0_ar_pop, e_pop0);
            chk("pop1", req1_ar_pop, e_pop1);
            chk("arvalid", arvalid, m_arv);
            chk("outstanding_cnt", ocnt, m_cnt);
            chk("arb_err", err, m_err);
            if (arvalid && arready && !reset) begin
                hs_ids.push_back(arid[0]);
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL ar_unexpected got=%0h want=none", araddr);
                end else begin
                    e = exp_q.pop_front();
                    chk("araddr", araddr, e[31:0]);
                    chk("arid", arid, {3'b000, e[32]});
                    chk("arlen", arlen, 8'd7);
                    chk("arsize", arsize, 3'd4);
                    chk("arburst", arburst, 2'b01);
                end
            end
        end
    end

    task automatic do_reset();
        k_rst = 1; cycle();
        k_rst = 0; cycle();
    endtask

    task automatic drain();
        int n = 0;
        k_ardy = 1; k_r = 2;
        while ((m_cnt > 0 || m_arv || q0.size() > 0 || q1.size() > 0) && n < 200) begin
            cycle();
            n++;
        end
        k_r = 0;
        cycle();
        if (n >= 200) begin
            total++; bad++;
            $display("FAIL drain_timeout got=%0d want=0", m_cnt);
        end
    endtask

    initial begin
        repeat (3) cycle();
        k_rst = 0;
        cycle();
        chk("rst_arvalid", arvalid, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_arid", arid, 0);
        chk("rst_cnt", ocnt, 0);
        chk("rst_err", err, 0);
        mon_on = 1;

        // single requester
        q0.push_back(32'h0001_0000);
        k_ardy = 1;
        cycle();
        #1 chk("single_pop0", req0_ar_pop, 1);
        cycle();
        chk("single_arvalid", arvalid, 1);
        chk("single_araddr", araddr, 32'h0001_0000);
        chk("single_arid", arid, 0);
        chk("single_cnt", ocnt, 1);
        drain();

        // contention after reset: 0,1,0,1,...
        do_reset();
        hs_ids.delete();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(32'h0000_1000 + 32'(i * 64));
            q1.push_back(32'h0000_2000 + 32'(i * 64));
        end
        k_ardy = 1;
        repeat (10) cycle();
        chk("rr_count", hs_ids.size(), 8);
        for (int i = 0; i < 8 && i < hs_ids.size(); i++)
            chk("rr_order", hs_ids[i], i % 2);
        drain();

        // backpressure
        q0.push_back(32'h0000_C000);
        q0.push_back(32'h0000_C040);
        k_ardy = 0;
        repeat (2) cycle();
        for (int i = 0; i < 5; i++) begin
            cycle();
            #1;
            chk("bp_araddr", araddr, 32'h0000_C000);
            chk("bp_arid", arid, 0);
            chk("bp_nopop", req0_ar_pop, 0);
        end
        k_ardy = 1;
        cycle();
        #1 chk("bp_release_pop", req0_ar_pop, 1);
        cycle();
        chk("bp_next_addr", araddr, 32'h0000_C040);
        drain();

        // credit limit
        hs_ids.delete();
        for (int i = 0; i < 10; i++) q0.push_back(32'h0004_0000 + 32'(i * 128));
        k_ardy = 1; k_r = 0;
        repeat (15) cycle();
        chk("credit_cnt", ocnt, 8);
        chk("credit_ars", hs_ids.size(), 8);
        k_r = 3; cycle(); k_r = 0;
        #1 chk("credit_hold_pop", req0_ar_pop, 0);
        cycle();
        #1 chk("credit_free_pop", req0_ar_pop, 1);
        cycle();
        chk("credit_cnt_after", ocnt, 8);
        cycle();
        chk("credit_ars_after", hs_ids.size(), 9);
        drain();

        // simultaneous inc/dec, then underflow
        for (int i = 0; i < 3; i++) q1.push_back(32'h0008_0000 + 32'(i * 128));
        repeat (5) cycle();
        chk("incdec_pre", ocnt, 3);
        q1.push_back(32'h0008_1000);
        k_r = 3; cycle(); k_r = 0;
        cycle();
        chk("incdec_cnt", ocnt, 3);
        drain();
        k_r = 3; cycle(); k_r = 0;
        cycle();
        chk("underflow_err", err, 1);
        chk("underflow_cnt", ocnt, 0);

        // reset mid-operation
        for (int i = 0; i < 5; i++) q0.push_back(32'h000A_0000 + 32'(i * 128));
        k_ardy = 1;
        repeat (5) cycle();
        k_ardy = 0;
        cycle();
        chk("mid_arvalid", arvalid, 1);
        chk("mid_cnt", ocnt, 5);
        do_reset();
        chk("post_rst_arvalid", arvalid, 0);
        chk("post_rst_cnt", ocnt, 0);
        chk("post_rst_err", err, 0);
        hs_ids.delete();
        q0.push_back(32'h000B_0000);
        q1.push_back(32'h000B_1000);
        k_ardy = 1;
        repeat (5) cycle();
        chk("post_rst_hs", hs_ids.size(), 2);
        if (hs_ids.size() > 0) chk("post_rst_first", hs_ids[0], 0);
        drain();

        // randomized traffic
        k_ardy = 2; k_r = 1;
        for (int c = 0; c < 3000; c++) begin
            if (q0.size() < 6 && $urandom_range(0, 2) == 0) q0.push_back($urandom);
            if (q1.size() < 6 && $urandom_range(0, 2) == 0) q1.push_back($urandom);
            cycle();
        end
        drain();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
